// File: rtl/life_pkg.sv
// Shared definitions for grid-level blocks: scan FSM states and width helpers.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int popWidth(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_popcount.sv
// Combinational count of set bits in one grid row.
module row_popcount
    import life_pkg::*;
#(
    parameter int COLS = 8,
    localparam int CW  = popWidth(COLS)
) (
    input  logic [COLS-1:0] row_i,
    output logic [CW-1:0]   count_o
);

    always_comb begin
        count_o = '0;
        for (int c = 0; c < COLS; c++) begin
            count_o = count_o + CW'(row_i[c]);
        end
    end

endmodule

// File: rtl/life_frame_scan.sv
// Snapshots the cell grid on request, streams it out row by row over a
// valid/ready link, and reports per-frame population/stability statistics.
module life_frame_scan
    import life_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int CNT_W = 16,
    localparam int CELLS  = ROWS * COLS,
    localparam int POP_W  = popWidth(CELLS),
    localparam int IDX_W  = idxWidth(ROWS),
    localparam int RPOP_W = popWidth(COLS)
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             snap,
    input  logic [CELLS-1:0] grid_in,
    output logic             busy,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [COLS-1:0]  row_data,
    output logic [IDX_W-1:0] row_idx,
    output logic             frame_done,
    output logic [POP_W-1:0] pop_count,
    output logic [CNT_W-1:0] gen_count,
    output logic             stable,
    output logic             extinct,
    output logic             overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    scan_state_e      state_q, state_d;
    logic [CELLS-1:0] snapReg_q;
    logic [CELLS-1:0] shadow_q;
    logic             prevValid_q;
    logic             same_q;
    logic [POP_W-1:0] acc_q;
    logic [IDX_W-1:0] rowIdx_q;
    logic [CNT_W-1:0] genCount_q;
    logic [POP_W-1:0] popCount_q;
    logic             stable_q;
    logic             extinct_q;
    logic             overrun_q;
    logic [RPOP_W-1:0] rowPop;
    logic             accept;
    logic             handshake;

    assign accept    = (state_q == IDLE) && snap;
    assign handshake = (state_q == SEND) && row_ready;

    row_popcount #(.COLS(COLS)) u_row_popcount (
        .row_i   (row_data),
        .count_o (rowPop)
    );

    always_ff @(posedge clk) begin
        if (_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (snap) state_d = SEND;
            SEND:    if (row_ready && rowIdx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        row_valid  = (state_q == SEND);
        frame_done = (state_q == DONE);
        row_data   = snapReg_q[int'(rowIdx_q) * COLS +: COLS];
        row_idx    = rowIdx_q;
        pop_count  = popCount_q;
        gen_count  = genCount_q;
        stable     = stable_q;
        extinct    = extinct_q;
        overrun    = overrun_q;
    end

    // Statistics commit only in DONE, so an aborted frame never disturbs them.
    always_ff @(posedge clk) begin
        if (_rst) begin
            snapReg_q   <= '0;
            shadow_q    <= '0;
            prevValid_q <= 1'b0;
            same_q      <= 1'b0;
            acc_q       <= '0;
            rowIdx_q    <= '0;
            genCount_q  <= '0;
            popCount_q  <= '0;
            stable_q    <= 1'b0;
            extinct_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (accept) begin
                snapReg_q   <= grid_in;
                same_q      <= prevValid_q && (grid_in == shadow_q);
                shadow_q    <= grid_in;
                prevValid_q <= 1'b1;
                genCount_q  <= genCount_q + CNT_W'(1);
                acc_q       <= '0;
                rowIdx_q    <= '0;
            end
            if (handshake) begin
                acc_q <= acc_q + POP_W'(rowPop);
                if (rowIdx_q != LAST_IDX) begin
                    rowIdx_q <= rowIdx_q + IDX_W'(1);
                end
            end
            if (state_q == DONE) begin
                popCount_q <= acc_q;
                stable_q   <= same_q;
                extinct_q  <= (acc_q == '0);
            end
            if (snap && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_life_frame_scan.sv
// Randomized self-checking bench for life_frame_scan on a 4x4 grid with a
// 2-bit generation counter, compared against a frame-level reference model.
module tb_life_frame_scan;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CNT_W = 2;
    localparam int N     = ROWS * COLS;

    logic           clk = 1'b0;
    logic           rst;
    logic           snap;
    logic [N-1:0]   grid_in;
    logic           busy;
    logic           row_valid;
    logic           row_ready;
    logic [COLS-1:0] row_data;
    logic [1:0]     row_idx;
    logic           frame_done;
    logic [4:0]     pop_count;
    logic [CNT_W-1:0] gen_count;
    logic           stable;
    logic           extinct;
    logic           overrun;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] prevFrame;
    bit           prevValid;
    int           expGen, expPop;
    bit           expStable, expExtinct, expOverrun;

    life_frame_scan #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        ._rst       (rst),
        .snap       (snap),
        .grid_in    (grid_in),
        .busy       (busy),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .frame_done (frame_done),
        .pop_count  (pop_count),
        .gen_count  (gen_count),
        .stable     (stable),
        .extinct    (extinct),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int onesIn(input logic [N-1:0] v);
        int n = 0;
        for (int i = 0; i < N; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [COLS-1:0] rowOf(input logic [N-1:0] v, input int r);
        return COLS'((v >> (r * COLS)) & ((1 << COLS) - 1));
    endfunction

    task automatic modelReset();
        prevValid  = 0;
        prevFrame  = '0;
        expGen     = 0;
        expPop     = 0;
        expStable  = 0;
        expExtinct = 0;
        expOverrun = 0;
    endtask

    task automatic checkStats(input string where);
        checkOutput({where, ".pop"}, 32'(pop_count), 32'(expPop));
        checkOutput({where, ".gen"}, 32'(gen_count), 32'(expGen));
        checkOutput({where, ".stable"}, 32'(stable), 32'(expStable));
        checkOutput({where, ".extinct"}, 32'(extinct), 32'(expExtinct));
        checkOutput({where, ".overrun"}, 32'(overrun), 32'(expOverrun));
    endtask

    task automatic checkRow(input logic [N-1:0] grid, input int r);
        checkOutput("row_valid", 32'(row_valid), 32'd1);
        checkOutput("busy", 32'(busy), 32'd1);
        checkOutput("row_idx", 32'(row_idx), 32'(r));
        checkOutput("row_data", 32'(row_data), 32'(rowOf(grid, r)));
        checkOutput("frame_done", 32'(frame_done), 32'd0);
    endtask

    // One full frame: snap, stream all rows with optional stalls, check stats.
    task automatic applyStimulus(input logic [N-1:0] grid, input int maxStall,
                                 input int stallRow, input int stallCycles, input bit snapMid);
        bit pendSame;
        int pendPop;
        snap      = 1'b1;
        grid_in   = grid;
        row_ready = 1'($urandom_range(0, 1));
        step();
        snap      = 1'b0;
        pendSame  = prevValid && (grid == prevFrame);
        pendPop   = onesIn(grid);
        prevFrame = grid;
        prevValid = 1;
        expGen    = (expGen + 1) % (1 << CNT_W);
        for (int r = 0; r < ROWS; r++) begin
            int stalls = (r == stallRow) ? stallCycles : $urandom_range(0, maxStall);
            checkRow(grid, r);
            for (int s = 0; s < stalls; s++) begin
                row_ready = 1'b0;
                step();
                checkRow(grid, r);
            end
            row_ready = 1'b1;
            if (snapMid && r == 1) begin
                snap       = 1'b1;
                grid_in    = ~grid;
                expOverrun = 1;
            end
            step();
            snap    = 1'b0;
            grid_in = grid;
        end
        row_ready = 1'($urandom_range(0, 1));
        checkOutput("done.frame_done", 32'(frame_done), 32'd1);
        checkOutput("done.row_valid", 32'(row_valid), 32'd0);
        checkOutput("done.busy", 32'(busy), 32'd1);
        step();
        expPop     = pendPop;
        expStable  = pendSame;
        expExtinct = (pendPop == 0);
        checkOutput("idle.frame_done", 32'(frame_done), 32'd0);
        checkOutput("idle.busy", 32'(busy), 32'd0);
        checkOutput("idle.row_valid", 32'(row_valid), 32'd0);
        checkStats("idle");
    endtask

    initial begin
        logic [N-1:0] lastGrid;
        logic [N-1:0] g;
        rst = 1'b1; snap = 1'b0; grid_in = '0; row_ready = 1'b0;
        modelReset();
        step(); step();
        rst = 1'b0;
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.row_valid", 32'(row_valid), 32'd0);
        checkOutput("rst.row_idx", 32'(row_idx), 32'd0);
        checkOutput("rst.row_data", 32'(row_data), 32'd0);
        checkOutput("rst.frame_done", 32'(frame_done), 32'd0);
        checkStats("rst");

        // Idle ready must not start anything.
        row_ready = 1'b1;
        step();
        checkOutput("idle_ready.row_valid", 32'(row_valid), 32'd0);

        applyStimulus(16'h0660, 0, -1, 0, 0);
        applyStimulus(16'h0660, 0, -1, 0, 0);
        applyStimulus(16'h0270, 0, -1, 0, 0);
        applyStimulus(16'h0660, 0, 2, 3, 0);
        applyStimulus(16'h0000, 0, -1, 0, 0);
        applyStimulus(16'h0660, 1, -1, 0, 1);
        applyStimulus(16'hFFFF, 0, -1, 0, 0);

        // Abort a frame with reset while row 1 is presented.
        snap = 1'b1; grid_in = 16'hFFFF; row_ready = 1'b1;
        step();
        snap = 1'b0;
        step();
        checkOutput("abort.row_idx", 32'(row_idx), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        modelReset();
        checkOutput("abort.row_valid", 32'(row_valid), 32'd0);
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkOutput("abort.frame_done", 32'(frame_done), 32'd0);
        checkStats("abort");
        step();
        checkOutput("abort2.frame_done", 32'(frame_done), 32'd0);
        applyStimulus(16'hFFFF, 0, -1, 0, 0);

        lastGrid = 16'hFFFF;
        for (int i = 0; i < 24; i++) begin
            g = ($urandom_range(0, 3) == 0) ? lastGrid : N'($urandom);
            applyStimulus(g, 2, -1, 0, ($urandom_range(0, 4) == 0));
            lastGrid = g;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_frame_scan.md
Name: life_frame_scan

Overview:
- Downstream consumer of the life cell array: takes a snapshot of the flat ROWS*COLS Status vector on a `snap` strobe.
- Streams the snapshot out one row per valid/ready handshake to a display or host link.
- Accumulates frame statistics (population, generation number, still-life and extinction flags) while streaming.
- Sits between the cell grid and the output/display interface.

Parameters:
ROWS, 8, grid rows
COLS, 8, grid columns (row_data width)
CNT_W, 16, generation counter width

Ports:
clk  in  1  clock; cell grid is clocked from the same clock
_rst  in  1  synchronous active-high reset
snap  in  1  capture request; sampled every clk
grid_in  in  ROWS*COLS  cell Status vector; cell (r,c) at bit r*COLS+c
busy  out  1  high from snapshot accept until frame_done
row_valid  out  1  row_data/row_idx valid
row_ready  in  1  consumer accepts row when row_valid&row_ready
row_data  out  COLS  current row; bit c = column c
row_idx  out  $clog2(ROWS)  index of row on row_data
frame_done  out  1  one-cycle pulse after last row accepted
pop_count  out  $clog2(ROWS*COLS+1)  live cells in last completed frame
gen_count  out  CNT_W  number of accepted snapshots, mod 2^CNT_W
stable  out  1  last completed frame identical to the previous accepted frame
extinct  out  1  last completed frame had pop_count==0
overrun  out  1  sticky: snap arrived while busy; cleared only by reset

Behaviour:
- Reset values (synchronous, _rst=1 at a clk edge): state=IDLE, busy=0, row_valid=0, row_idx=0, row_data=0, frame_done=0, pop_count=0, gen_count=0, stable=0, extinct=0, overrun=0. Shadow copy invalid.
- Reset mid-frame aborts the frame; no frame_done, statistics not updated.
- FSM has three states: IDLE, SEND, DONE.
- IDLE, snap=1: on this edge, latch grid_in into snap_reg.
  - Compute same = prev_valid & (grid_in==shadow); store it in same_r.
  - shadow<=grid_in; prev_valid<=1; gen_count<=gen_count+1, wrapping.
  - Clear pop accumulator; row_idx<=0; go to SEND.
  - busy and row_valid are 1 on the next cycle: latency snap->row_valid is one cycle.
- SEND:
  - row_valid=1.
  - row_data = snap_reg[row_idx*COLS +: COLS], registered or driven from snap_reg. It is stable while row_valid&!row_ready.
  - On handshake: acc<=acc+popcount(row_data).
    - If row_idx==ROWS-1: go to DONE and drop row_valid.
    - Otherwise row_idx<=row_idx+1.
  - No handshake: hold all outputs. row_valid never drops without a handshake.
- DONE, one cycle:
  - frame_done=1.
  - pop_count<=acc, stable<=same_r, extinct<=(acc==0). These update on the edge entering IDLE, so they are visible from the cycle after frame_done.
  - busy=0 in the following IDLE cycle.
- snap while in SEND or DONE: ignored (no capture, gen_count unchanged) and overrun<=1.
- snap in the IDLE cycle immediately after DONE is accepted normally. Back-to-back frame throughput is ROWS+2 cycles minimum.
- First frame after reset: stable=0 regardless of content.
- Widths:
  - Accumulator is $clog2(ROWS*COLS+1) bits; no overflow possible.
  - Per-row popcount is $clog2(COLS+1) bits, zero-extended.
  - gen_count wraps 2^CNT_W-1 -> 0 silently.
- row_ready high while row_valid is low has no effect.

Decomposition:
- Shared package/header (life_pkg) holds the FSM state encodings (IDLE, SEND, DONE) and the POP_W/IDX_W derivation helpers, reusable by other grid-level blocks.
- One sub-module: row_popcount (parameter COLS; combinational count of ones in a COLS-bit vector).
- The FSM, shadow register and counters stay in life_frame_scan.

Test Plan:
- ROWS=COLS=4, reset, snap with grid_in=16'h0660 (block), row_ready=1 -> rows 0x0,0x6,0x6,0x0 on consecutive cycles starting 1 cycle after snap; frame_done on cycle 6; then pop_count=4, gen_count=1, stable=0, extinct=0.
- Repeat snap with the same 16'h0660 -> stable=1, gen_count=2. Snap 16'h0270 (blinker-like) -> stable=0, pop_count=4.
- Backpressure: row_ready low for 3 cycles on row 2 -> row_valid stays 1, row_idx=2 and row_data held; accumulation counts row 2 exactly once; final pop_count is correct.
- snap=16'h0000 -> extinct=1, pop_count=0. Snap asserted during SEND -> overrun=1 sticky, gen_count not incremented, frame content unchanged.
- _rst asserted while row_idx=1 -> next cycle row_valid=0, busy=0, gen_count=0, no frame_done. The following snap gives stable=0.
- gen_count wrap with CNT_W=2: after 4 accepted snaps gen_count=0. All-ones grid (16'hFFFF) gives pop_count=16 with no truncation.
